// File: rtl/bp_update_scheduler_if.sv
// Commit-to-predictor update bus for bp_update_scheduler: commit-side push ports and
// predictor-side drain port, plus the starvation and occupancy status outputs.
interface bp_update_scheduler_if #(
    parameter int INSTR_COUNT = 2,
    parameter int DEPTH       = 8,
    parameter int UPD_BITS    = 72
);
    logic [INSTR_COUNT-1:0]          in_valid;
    logic [INSTR_COUNT*UPD_BITS-1:0] in_upd;
    logic                            in_ready;
    logic                            upd_valid;
    logic [UPD_BITS-1:0]             upd_data;
    logic                            upd_ready;
    logic                            force_prio;
    logic [$clog2(DEPTH+1)-1:0]      occupancy;

    // The commit side and the predictor model drive this end.
    modport master (
        output in_valid,
        output in_upd,
        output upd_ready,
        input  in_ready,
        input  upd_valid,
        input  upd_data,
        input  force_prio,
        input  occupancy
    );

    // The scheduler itself.
    modport slave (
        input  in_valid,
        input  in_upd,
        input  upd_ready,
        output in_ready,
        output upd_valid,
        output upd_data,
        output force_prio,
        output occupancy
    );
endinterface

// File: rtl/bp_update_scheduler.sv
// Buffers committed branch-predictor updates (up to two per cycle) in an in-order FIFO
// and drains one per cycle into the predictor write port, flagging write-port starvation.
module bp_update_scheduler #(
    parameter int INSTR_COUNT  = 2,
    parameter int DEPTH        = 8,
    parameter int UPD_BITS     = 72,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bp_update_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam int VJ    = UPD_BITS - 1;

    logic [UPD_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [ST_W-1:0]     starve_cnt;

    logic [UPD_BITS-1:0]    rec  [INSTR_COUNT];
    logic [INSTR_COUNT-1:0] push;
    logic [1:0]             push_cnt;
    logic [PTR_W-1:0]       wr_addr1;
    logic                   in_ready_int;
    logic                   not_empty;
    logic                   pop;
    logic [CNT_W-1:0]       count_next;

    // Only two commit ports are supported; the loop just unpacks the flat bus.
    always_comb begin
        for (int i = 0; i < INSTR_COUNT; i++) begin
            rec[i] = bus.in_upd[i*UPD_BITS +: UPD_BITS];
        end
    end

    // Space for a full pair is required so both ports can be accepted together.
    assign in_ready_int = (count <= CNT_W'(DEPTH - 2));
    assign not_empty    = (count != '0);
    assign pop          = not_empty & bus.upd_ready;

    always_comb begin
        push = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            push[i] = bus.in_valid[i] & in_ready_int & rec[i][VJ];
        end
    end

    assign push_cnt   = {1'b0, push[0]} + {1'b0, push[1]};
    assign wr_addr1   = push[0] ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    assign count_next = count + CNT_W'(push_cnt) - CNT_W'(pop);

    // NOTE: the storage array has no reset; upd_data is gated by not_empty, so stale
    // contents are never visible and reset only needs to clear pointers and count.
    always_ff @(posedge clk) begin
        if (push[0]) mem[wr_ptr]   <= rec[0];
        if (push[1]) mem[wr_addr1] <= rec[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_next;
        end
    end

    // Counts consecutive blocked cycles with a head present, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop || !not_empty) begin
            starve_cnt <= '0;
        end else if (!bus.upd_ready && (starve_cnt != ST_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + ST_W'(1);
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.upd_valid  = not_empty;
    assign bus.upd_data   = not_empty ? mem[rd_ptr] : '0;
    assign bus.force_prio = (starve_cnt == ST_W'(STARVE_LIMIT));
    assign bus.occupancy  = count;
endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sits between the commit side and the branch-predictor structures (BTB, gshare counters, RAS repair) of the IF stage.
- Each cycle it accepts up to INSTR_COUNT predictor_update records, drops records without valid_jump, and buffers the rest in order in a FIFO.
- It drains one record per cycle into the predictor's single write port.
- If the predictor withholds the port from updates for too long, it raises a priority request so fetch-side lookups yield.

Parameters:
- INSTR_COUNT, 2, number of commit update ports; only 2 is supported.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- UPD_BITS, 72, width of a packed predictor_update: valid_jump[71], jump_taken[70], is_comp[69], rat_id[68:67], orig_pc[66:35], jump_address[34:3], ticket[2:0].
- STARVE_LIMIT, 4, consecutive blocked cycles before force_prio asserts; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  INSTR_COUNT  per-port update strobe; port 0 is older than port 1.
- in_upd  in  INSTR_COUNT*UPD_BITS  update records; port i occupies bits [i*UPD_BITS +: UPD_BITS].
- in_ready  out  1  shared ready; both ports are accepted together or not at all.
- upd_valid  out  1  FIFO head is presented to the predictor.
- upd_data  out  UPD_BITS  FIFO head record.
- upd_ready  in  1  predictor write port is free this cycle.
- force_prio  out  1  update path is starved; fetch must yield the write port.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset (async assert, sync deassert on clk):
  - wr_ptr, rd_ptr, count and starve_cnt clear to 0.
  - upd_valid=0, upd_data=0, force_prio=0, occupancy=0, in_ready=1.
  - Reset mid-operation discards all buffered updates.
- in_ready = (DEPTH - count) >= 2.
  - Computed from registered count only; a same-cycle pop does not raise it (no combinational path from upd_ready to in_ready).
- Push condition: port i is pushed when in_valid[i] & in_ready & in_upd[i].valid_jump.
  - Records with valid_jump=0 are consumed and dropped, never stored.
- Push ordering:
  - Both ports push: port 0 is written at wr_ptr, port 1 at wr_ptr+1, and wr_ptr advances by 2.
  - One port pushes: it is written at wr_ptr and wr_ptr advances by 1.
  - Pointers wrap modulo DEPTH.
- Inputs presented while in_ready=0 are ignored. The upstream holds them; this block does not latch them.
- Output side:
  - upd_valid = (count != 0).
  - upd_data = mem[rd_ptr], driven from registered storage, so it is valid in the cycle after the push (1-cycle latency from an empty FIFO).
  - Pop on upd_valid & upd_ready: rd_ptr increments and wraps.
  - upd_data holds stable while upd_valid=1 and upd_ready=0.
- Count update: count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1.
  - Push and pop in the same cycle are legal, including when count=DEPTH-2.
  - count never exceeds DEPTH and never underflows.
- Empty with a push this cycle: no bypass. upd_valid rises the next cycle.
- Starvation counter:
  - When upd_valid & ~upd_ready: starve_cnt = min(starve_cnt+1, STARVE_LIMIT).
  - On a pop, or when count=0: starve_cnt clears to 0.
  - force_prio = (starve_cnt == STARVE_LIMIT), registered.
  - It stays asserted until the cycle after the first pop.
- occupancy = count (registered).
- No flush input: committed updates are architectural and are never squashed.

Test Plan:
- Basic ordering: reset, then one cycle with in_valid=2'b11 and records A (orig_pc=0x100, ticket=1) and B (orig_pc=0x104, ticket=2), upd_ready=1 → upd_valid=1 on the next cycle with A, then B on the following cycle, then upd_valid=0; occupancy goes 2,1,0.
- Filter: in_valid=2'b11 with port 0 valid_jump=0 and port 1 valid_jump=1 (orig_pc=0x200) → exactly one entry stored (occupancy=1), and upd_data.orig_pc=0x200.
- Full/backpressure: upd_ready=0, push pairs for 4 cycles with DEPTH=8 → occupancy reaches 8 and in_ready=0 from when count=7 or 8; a fifth pair held for 2 cycles is not stored. Raise upd_ready → drain order equals push order across the pointer wrap.
- Simultaneous push/pop at count=6: push 2 and pop 1 in one cycle → occupancy=7, in_ready=0, no overflow, head advances by one.
- Starvation: one entry stored, upd_ready=0 for 6 cycles → force_prio rises exactly 4 cycles after upd_valid rises. With upd_ready=1 for 1 cycle → pop, then force_prio=0 on the next cycle.
- Async reset: assert rst_n=0 mid-cycle with occupancy=5 → upd_valid, force_prio and occupancy go to 0 immediately, without waiting for a clock edge; after release, in_ready=1 and the first new push appears intact at upd_data.
